writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the number of architectural registers; the register address width is 5 bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port regWrite_Wb_In, input, 1, SHALL be the register write enable from the MEM/WB pipeline register.
REQ-006 Port memToRegWrite_Wb_In, input, 1, SHALL be the writeback source select (1 = memory data, 0 = ALU result).
REQ-007 Port readD_Wb_In, input, DATA_W, SHALL be the memory load data.
REQ-008 Port aluOut_Wb_In, input, DATA_W, SHALL be the ALU result.
REQ-009 Port rd_Wb_In, input, 5, SHALL be the destination register index.
REQ-010 Port rs1_Id_In, input, 5, SHALL be the decode-stage read address 1.
REQ-011 Port rs2_Id_In, input, 5, SHALL be the decode-stage read address 2.
REQ-012 Port rd1_Id_Out, output, DATA_W, SHALL be the read data for rs1_Id_In.
REQ-013 Port rd2_Id_Out, output, DATA_W, SHALL be the read data for rs2_Id_In.
REQ-014 Port wbData_Out, output, DATA_W, SHALL be the selected writeback value, exported for EX forwarding.
REQ-015 Port wbValid_Out, output, 1, SHALL indicate that the current writeback commits to a register other than x0.
REQ-016 Port wbCount_Out, output, 32, SHALL be the count of committed register writes.

Function
REQ-017 wbData_Out SHALL be combinational: readD_Wb_In when memToRegWrite_Wb_In=1, else aluOut_Wb_In.
REQ-018 wbValid_Out SHALL be combinational: regWrite_Wb_In AND (rd_Wb_In != 0) AND NOT rst.
REQ-019 On a rising clk edge with wbValid_Out=1, register[rd_Wb_In] SHALL take wbData_Out; all other registers hold.
REQ-020 Register x0 SHALL always read 0; writes to x0 SHALL be discarded and SHALL NOT increment wbCount_Out.
REQ-021 Reads SHALL be combinational with zero-cycle latency.
REQ-022 Write-first bypass: when wbValid_Out=1 and rsN_Id_In == rd_Wb_In, rdN_Id_Out SHALL equal wbData_Out in the same cycle.
REQ-023 When both read addresses match rd_Wb_In, both outputs SHALL be bypassed.
REQ-024 When regWrite_Wb_In=0, no bypass SHALL occur, even if the addresses match.
REQ-025 wbCount_Out SHALL increment by 1 on each clock edge with wbValid_Out=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Inputs with X or unused values on the data ports SHALL NOT affect state when regWrite_Wb_In=0.

Reset
REQ-027 On a rising clk edge with rst=1, all registers and wbCount_Out SHALL be set to 0.
REQ-028 While rst=1, writes SHALL be suppressed, rd1_Id_Out and rd2_Id_Out SHALL read 0, and wbValid_Out SHALL be 0.
REQ-029 If rst asserts in the same cycle as a valid write, reset SHALL take priority and the write SHALL be lost.

Structure
REQ-030 DATA_W, REG_ADDR_W (5) and NUM_REGS SHALL be defined in the shared package riscv_pkg.
REQ-031 The storage array with its write port SHALL be a sub-module named regfile_bank; the source mux, bypass logic and counter SHALL be in the top level.

Verification
REQ-032 Reset followed by a read of all 32 addresses -> every read returns 0x00000000 and wbCount_Out=0.
REQ-033 Write x5 with aluOut=0x12345678 (memToReg=0), then read x5 on the next cycle -> rd1_Id_Out=0x12345678 and wbCount_Out=1.
REQ-034 Write x7 with readD=0xDEADBEEF (memToReg=1) while rs1=rs2=7 in the same cycle -> both outputs=0xDEADBEEF in that cycle (bypass).
REQ-035 Write x0 with aluOut=0xFFFFFFFF -> a read of x0 returns 0, wbValid_Out=0, and wbCount_Out is unchanged.
REQ-036 rst=1 together with a write of x3=0xA5A5A5A5 -> on the next cycle x3 reads 0 and wbCount_Out=0.
REQ-037 Preload the counter path to 0xFFFFFFFF via forced writes, then perform one more valid write -> wbCount_Out=0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and writeback types for the register file slice
package riscv_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int WB_COUNT_W  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  // x0 is hardwired, so it never names a real destination.
  function automatic logic is_real_dest(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - architectural register storage, one write port, two async read ports
module regfile_bank #(
  parameter int DATA_W   = riscv_pkg::DATA_W,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int ADDR_W   = riscv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              waddr_ok;
  logic              raddr1_ok;
  logic              raddr2_ok;

  // Entry 0 exists only to keep indexing simple; it is never written or read.
  assign waddr_ok  = (waddr  != '0) && (int'(waddr)  < NUM_REGS);
  assign raddr1_ok = (raddr1 != '0) && (int'(raddr1) < NUM_REGS);
  assign raddr2_ok = (raddr2 != '0) && (int'(raddr2) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = raddr1_ok ? regs[raddr1] : '0;
  assign rdata2 = raddr2_ok ? regs[raddr2] : '0;

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback source mux, write-first read bypass and commit counter
module writeback_regfile #(
  parameter int DATA_W   = riscv_pkg::DATA_W,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             regWrite_Wb_In,
  input  logic                             memToRegWrite_Wb_In,
  input  logic [DATA_W-1:0]                readD_Wb_In,
  input  logic [DATA_W-1:0]                aluOut_Wb_In,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rd_Wb_In,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs1_Id_In,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs2_Id_In,
  output logic [DATA_W-1:0]                rd1_Id_Out,
  output logic [DATA_W-1:0]                rd2_Id_Out,
  output logic [DATA_W-1:0]                wbData_Out,
  output logic                             wbValid_Out,
  output logic [riscv_pkg::WB_COUNT_W-1:0] wbCount_Out
);

  import riscv_pkg::*;

  wb_src_e                 wb_src;
  logic [DATA_W-1:0]       wb_data;
  logic                    wb_valid;
  logic [DATA_W-1:0]       bank_rd1;
  logic [DATA_W-1:0]       bank_rd2;
  logic                    bypass1;
  logic                    bypass2;
  logic [WB_COUNT_W-1:0]   count_q;

  assign wb_src = wb_src_e'(memToRegWrite_Wb_In);

  always_comb begin
    wb_data = aluOut_Wb_In;
    case (wb_src)
      WB_SRC_MEM: wb_data = readD_Wb_In;
      WB_SRC_ALU: wb_data = aluOut_Wb_In;
      default:    wb_data = aluOut_Wb_In;
    endcase
  end

  assign wb_valid = regWrite_Wb_In && is_real_dest(rd_Wb_In) && !rst;

  regfile_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_valid),
    .waddr  (rd_Wb_In),
    .wdata  (wb_data),
    .raddr1 (rs1_Id_In),
    .raddr2 (rs2_Id_In),
    .rdata1 (bank_rd1),
    .rdata2 (bank_rd2)
  );

  // Write-first: decode sees the value committing this cycle, never the stale copy.
  assign bypass1 = wb_valid && (rs1_Id_In == rd_Wb_In);
  assign bypass2 = wb_valid && (rs2_Id_In == rd_Wb_In);

  always_comb begin
    rd1_Id_Out = bank_rd1;
    rd2_Id_Out = bank_rd2;
    if (rst) begin
      rd1_Id_Out = '0;
      rd2_Id_Out = '0;
    end else begin
      if (bypass1) rd1_Id_Out = wb_data;
      if (bypass2) rd2_Id_Out = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (wb_valid) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign wbData_Out  = wb_data;
  assign wbValid_Out = wb_valid;
  assign wbCount_Out = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] read_d;
  logic [31:0] alu_out;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wb_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  always #5 clk = ~clk;

  writeback_regfile #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .regWrite_Wb_In      (reg_write),
    .memToRegWrite_Wb_In (mem_to_reg),
    .readD_Wb_In         (read_d),
    .aluOut_Wb_In        (alu_out),
    .rd_Wb_In            (rd),
    .rs1_Id_In           (rs1),
    .rs2_Id_In           (rs2),
    .rd1_Id_Out          (rd1),
    .rd2_Id_Out          (rd2),
    .wbData_Out          (wb_data),
    .wbValid_Out         (wb_valid),
    .wbCount_Out         (wb_count)
  );

  function automatic logic [31:0] exp_wb();
    return mem_to_reg ? read_d : alu_out;
  endfunction

  function automatic logic exp_valid();
    return reg_write && (rd != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (rst) return 32'd0;
    if (exp_valid() && a == rd) return exp_wb();
    if (a == 5'd0) return 32'd0;
    return model_regs[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (exp_valid()) begin
      model_regs[rd] = exp_wb();
      model_count = model_count + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0;
    read_d = 32'h1111_2222; alu_out = 32'h3333_4444;
    rd = 5'd3; rs1 = 5'd3; rs2 = 5'd3;
    tick();
    #1;
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid);
    end
    vectors++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      miscompares++; $display("FAIL reset_read_zero: got %h/%h expected 0/0", rd1, rd2);
    end
    tick();
    rst = 1'b0; reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      vectors++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_all_regs[%0d]: got %h/%h expected 0/0", i, rd1, rd2);
      end
    end
    vectors++;
    if (wb_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count: got %h expected 0", wb_count);
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; mem_to_reg = 1'b0; alu_out = 32'h1234_5678; read_d = 32'hCAFE_0000;
    rd = 5'd5; rs1 = 5'd1; rs2 = 5'd2;
    #1;
    vectors++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL alu_writeback: got valid=%b data=%h expected 1/12345678", wb_valid, wb_data);
    end
    tick();
    reg_write = 1'b0; rs1 = 5'd5;
    #1;
    vectors++;
    if (rd1 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL read_x5: got %h expected 12345678", rd1);
    end
    vectors++;
    if (wb_count !== 32'd1) begin
      miscompares++; $display("FAIL count_after_one: got %h expected 1", wb_count);
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b0; mem_to_reg = 1'b1; read_d = 32'hDEAD_BEEF; alu_out = $urandom;
    rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    vectors++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      miscompares++; $display("FAIL no_bypass_without_write: got %h/%h expected 0/0", rd1, rd2);
    end
    reg_write = 1'b1;
    #1;
    vectors++;
    if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL dual_bypass: got %h/%h expected deadbeef/deadbeef", rd1, rd2);
    end
    tick();
    reg_write = 1'b0; read_d = 32'd0;
    #1;
    vectors++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL read_x7_stored: got %h expected deadbeef", rd1);
    end
  endtask

  task automatic test_x0();
    logic [31:0] cnt_before;
    cnt_before = model_count;
    reg_write = 1'b1; mem_to_reg = 1'b0; alu_out = 32'hFFFF_FFFF;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || rd1 !== 32'd0) begin
      miscompares++; $display("FAIL x0_write_comb: got valid=%b rd1=%h expected 0/0", wb_valid, rd1);
    end
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (rd2 !== 32'd0 || wb_count !== cnt_before) begin
      miscompares++;
      $display("FAIL x0_discard: got rd2=%h count=%h expected 0/%h", rd2, wb_count, cnt_before);
    end
  endtask

  task automatic test_hold_without_write();
    reg_write = 1'b1; mem_to_reg = 1'b0; alu_out = 32'h0BAD_F00D; rd = 5'd9;
    tick();
    reg_write = 1'b0; mem_to_reg = 1'bx; read_d = 'x; alu_out = 'x; rd = 5'd9;
    rs1 = 5'd9; rs2 = 5'd5;
    tick();
    mem_to_reg = 1'b0; read_d = 32'd0; alu_out = 32'd0;
    #1;
    vectors++;
    if (rd1 !== 32'h0BAD_F00D || rd2 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL hold_no_write: got %h/%h expected 0badf00d/12345678", rd1, rd2);
    end
    vectors++;
    if (wb_count !== model_count) begin
      miscompares++; $display("FAIL hold_count: got %h expected %h", wb_count, model_count);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; alu_out = 32'hA5A5_A5A5;
    rd = 5'd3; rs1 = 5'd3; rs2 = 5'd7;
    tick();
    rst = 1'b0; reg_write = 1'b0;
    #1;
    vectors++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      miscompares++; $display("FAIL reset_priority_regs: got %h/%h expected 0/0", rd1, rd2);
    end
    vectors++;
    if (wb_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_priority_count: got %h expected 0", wb_count);
    end
  endtask

  task automatic test_counter_wrap();
    reg_write = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    model_count = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (wb_count !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL count_preload: got %h expected ffffffff", wb_count);
    end
    reg_write = 1'b1; mem_to_reg = 1'b1; read_d = 32'h0000_0A0A; rd = 5'd10; rs1 = 5'd10;
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (wb_count !== 32'd0) begin
      miscompares++; $display("FAIL count_wrap: got %h expected 0", wb_count);
    end
    vectors++;
    if (rd1 !== 32'h0000_0A0A) begin
      miscompares++; $display("FAIL wrap_write_x10: got %h expected 00000a0a", rd1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst        = ($urandom_range(0, 29) == 0);
      reg_write  = 1'($urandom_range(0, 1));
      mem_to_reg = 1'($urandom_range(0, 1));
      read_d     = $urandom;
      alu_out    = $urandom;
      rd         = 5'($urandom_range(0, 31));
      rs1        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (wb_data !== exp_wb()) begin
        miscompares++; $display("FAIL rand_wb_data[%0d]: got %h expected %h", n, wb_data, exp_wb());
      end
      vectors++;
      if (wb_valid !== exp_valid()) begin
        miscompares++; $display("FAIL rand_wb_valid[%0d]: got %b expected %b", n, wb_valid, exp_valid());
      end
      vectors++;
      if (rd1 !== exp_read(rs1)) begin
        miscompares++; $display("FAIL rand_rd1[%0d]: got %h expected %h", n, rd1, exp_read(rs1));
      end
      vectors++;
      if (rd2 !== exp_read(rs2)) begin
        miscompares++; $display("FAIL rand_rd2[%0d]: got %h expected %h", n, rd2, exp_read(rs2));
      end
      vectors++;
      if (wb_count !== model_count) begin
        miscompares++; $display("FAIL rand_count[%0d]: got %h expected %h", n, wb_count, model_count);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_hold_without_write();
    test_reset_priority();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
